// File: rtl/seq_sub_pkg.sv
// Shared types and sizing for the chunked 64-bit subtractor.
package seq_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH     = 64;
    localparam int DEF_CHUNK = 16;

    // Number of cycles spent in BUSY for a given chunk width.
    function automatic int nch(input int chunk);
        return WIDTH / chunk;
    endfunction

endpackage

// File: rtl/seq_sub_64_bit_sub_chunk.sv
// Combinational W-bit borrow subtractor: {bo, d} = x - y - bi.
module sub_chunk #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bi,
    output logic [W-1:0] d,
    output logic         bo
);

    logic [W:0] w_full;

    // The extra MSB goes to 1 exactly when x < y + bi.
    assign w_full = {1'b0, x} - {1'b0, y} - (W+1)'(bi);
    assign d      = w_full[W-1:0];
    assign bo     = w_full[W];

endmodule

// File: rtl/seq_sub_64_bit.sv
// Multi-cycle 64-bit subtractor: one CHUNK-bit slice per cycle, LSB first,
// with a registered borrow between slices and valid/ready on both sides.
module seq_sub_64_bit
    import seq_sub_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] diff,
    output logic        bout,
    output logic        ovf,
    output logic        zero
);

    localparam int NCH  = nch(CHUNK);
    localparam int IDXW = 7;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic [IDXW-1:0]  r_idx;
    logic             r_out_valid;
    logic             r_bout;
    logic             r_ovf;
    logic             r_zero;

    logic [CHUNK-1:0] w_x;
    logic [CHUNK-1:0] w_y;
    logic [CHUNK-1:0] w_d;
    logic             w_bo;
    logic             w_last;
    logic [WIDTH-1:0] w_diff_next;

    // Slice select and write-back are unrolled compares so every part-select
    // index is a constant.
    always_comb begin
        w_x         = '0;
        w_y         = '0;
        w_diff_next = r_diff;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_x = r_a[i*CHUNK +: CHUNK];
                w_y = r_b[i*CHUNK +: CHUNK];
                w_diff_next[i*CHUNK +: CHUNK] = w_d;
            end
        end
    end

    sub_chunk #(
        .W(CHUNK)
    ) u_sub_chunk (
        .x (w_x),
        .y (w_y),
        .bi(r_borrow),
        .d (w_d),
        .bo(w_bo)
    );

    assign w_last = (r_idx == IDXW'(NCH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_diff      <= '0;
            r_borrow    <= 1'b0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_bout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_idx    <= '0;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    r_diff   <= w_diff_next;
                    r_borrow <= w_bo;
                    r_idx    <= r_idx + 1'b1;
                    if (w_last) begin
                        // Signed overflow only when operand signs differ and
                        // the result sign disagrees with the minuend.
                        r_bout      <= w_bo;
                        r_ovf       <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) &
                                       (w_diff_next[WIDTH-1] ^ r_a[WIDTH-1]);
                        r_zero      <= (w_diff_next == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_seq_sub_64_bit.sv
// Directed bench: three instances (CHUNK = 8, 16, 64) driven in lockstep.
module tb_seq_sub_64_bit;

    localparam int NI = 3;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic        out_ready;

    logic        w_in_ready  [NI];
    logic        w_out_valid [NI];
    logic [63:0] w_diff      [NI];
    logic        w_bout      [NI];
    logic        w_ovf       [NI];
    logic        w_zero      [NI];

    int n_pass;
    int n_total;
    int exp_lat [NI];

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        bin;
        logic [63:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs [10];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        seq_sub_64_bit #(
            .CHUNK(g == 0 ? 8 : (g == 1 ? 16 : 64))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (w_in_ready[g]),
            .a        (a),
            .b        (b),
            .bin      (bin),
            .out_valid(w_out_valid[g]),
            .out_ready(out_ready),
            .diff     (w_diff[g]),
            .bout     (w_bout[g]),
            .ovf      (w_ovf[g]),
            .zero     (w_zero[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int inst,
                         input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s [dut%0d]: got %0h expected %0h", name, inst, act, exp);
    endtask

    // Accept one operation on all instances, time out_valid, check results, consume.
    task automatic run_vec(input vec_t v, input string tag);
        int lat [NI];
        @(negedge clk);
        a = v.a; b = v.b; bin = v.bin; in_valid = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < NI; k++) check({tag, " in_ready idle"}, k, 64'(w_in_ready[k]), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~v.a; b = ~v.b; bin = ~v.bin;
        for (int k = 0; k < NI; k++) lat[k] = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NI; k++)
                if (w_out_valid[k] && lat[k] == 0) lat[k] = c;
        end
        for (int k = 0; k < NI; k++) begin
            check({tag, " latency"}, k, 64'(lat[k]), 64'(exp_lat[k]));
            check({tag, " diff"},    k, w_diff[k], v.diff);
            check({tag, " bout"},    k, 64'(w_bout[k]), 64'(v.bout));
            check({tag, " ovf"},     k, 64'(w_ovf[k]),  64'(v.ovf));
            check({tag, " zero"},    k, 64'(w_zero[k]), 64'(v.zero));
            check({tag, " in_ready busy"}, k, 64'(w_in_ready[k]), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < NI; k++) check({tag, " out_valid drop"}, k, 64'(w_out_valid[k]), 64'd0);
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        exp_lat[0] = 8; exp_lat[1] = 4; exp_lat[2] = 1;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;

        vecs[0] = '{64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{64'h3EBF_3EBF_3EBF_3EBF, 64'h3EBF_3EBF_3EBF_3EBF, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{64'h3EBF_3EBF_3EBF_3EBF, 64'h3EBF_3EBF_3EBF_3EBF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{64'h8000_0000_0000_0000, 64'd0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h0246_8ACF_1357_9BCF, 1'b0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check("reset out_valid", k, 64'(w_out_valid[k]), 64'd0);
            check("reset diff",      k, w_diff[k], 64'd0);
            check("reset flags",     k, {61'd0, w_bout[k], w_ovf[k], w_zero[k]}, 64'd0);
            check("reset in_ready",  k, 64'(w_in_ready[k]), 64'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: a second request waits while the result is held.
        @(negedge clk);
        a = 64'd5; b = 64'd3; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        a = 64'd100; b = 64'd1;
        repeat (10) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check("bp in_ready",  k, 64'(w_in_ready[k]), 64'd0);
            check("bp out_valid", k, 64'(w_out_valid[k]), 64'd1);
            check("bp diff held", k, w_diff[k], 64'd2);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < NI; k++) begin
            check("bp handshake out_valid", k, 64'(w_out_valid[k]), 64'd0);
            check("bp handshake in_ready",  k, 64'(w_in_ready[k]), 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 0; k < NI; k++) check("bp second accepted", k, 64'(w_in_ready[k]), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check("bp second valid", k, 64'(w_out_valid[k]), 64'd1);
            check("bp second diff",  k, w_diff[k], 64'd99);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset two BUSY edges into an operation.
        @(negedge clk);
        a = 64'd0; b = 64'd1; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check("rst mid out_valid", k, 64'(w_out_valid[k]), 64'd0);
            check("rst mid diff",      k, w_diff[k], 64'd0);
            check("rst mid bout",      k, 64'(w_bout[k]), 64'd0);
            check("rst mid in_ready",  k, 64'(w_in_ready[k]), 64'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[9], "post-rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_sub_64_bit.md
# seq_sub_64_bit

Multi-cycle 64-bit unsigned/two's-complement subtractor computing diff = a − b − bin, the inverse operation of the 64-bit adder datapath. It processes the operands CHUNK bits per cycle, least significant chunk first, rippling a registered borrow between chunks. It uses a valid/ready handshake on both input and output, so it can sit between an operand source and a result consumer in the ALU datapath.

## Interface
- CHUNK, 16, bits processed per cycle; must divide 64 (legal: 8, 16, 32, 64)
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset; synchronous and active-low
- in_valid  input  1  operands a/b/bin valid this cycle
- in_ready  output  1  block can accept operands
- a  input  64  minuend
- b  input  64  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result valid, held until accepted
- out_ready  input  1  consumer accepts result
- diff  output  64  a − b − bin, modulo 2^64
- bout  output  1  unsigned borrow-out: 1 iff a < b + bin, evaluated as integers
- ovf  output  1  signed overflow: a − b − bin is not representable in 64-bit two's complement
- zero  output  1  diff == 0

## Operation
- NCH = 64/CHUNK. States: IDLE, BUSY, DONE.
- IDLE: in_ready = 1. When in_valid && in_ready at an edge:
  - capture a, b, bin into internal registers;
  - set chunk index idx = 0 and borrow register = bin;
  - go to BUSY.
- BUSY: each edge computes chunk idx as {borrow_next, diff_chunk} = a_chunk − b_chunk − borrow.
  - Writes diff_chunk into diff[idx*CHUNK +: CHUNK], updates borrow, then idx++.
  - On the edge that processes chunk NCH−1: latch bout = final borrow, compute ovf and zero, set out_valid = 1, go to DONE.
- DONE: out_valid = 1; diff, bout, ovf and zero are held stable. When out_valid && out_ready at an edge: out_valid = 0, go to IDLE.
- in_ready = (state == IDLE), combinational from state. No input is accepted in BUSY or DONE, and in_valid is ignored there.
- ovf = (borrow into bit 63) XOR (borrow out of bit 63). Equivalent form: a[63] != b[63] and diff[63] != a[63], with bin folded in.
- diff is updated chunk by chunk during BUSY, so its value is only meaningful while out_valid = 1.

## Timing
- Reset (rst_n low at an edge), applied from any state, including mid-BUSY:
  - state = IDLE, idx = 0, borrow = 0;
  - out_valid = 0, diff = 0, bout = 0, ovf = 0, zero = 0;
  - in_ready reads 1 from the next cycle.
  - Any in-flight operation is discarded and no partial result is ever presented.
- Latency: input accepted at edge E → out_valid high after edge E+NCH (4 cycles for CHUNK=16, 1 for CHUNK=64).
- Throughput: at most one operation per NCH+2 cycles (accept, NCH compute, ≥1 DONE, return to IDLE). A new operation is accepted no earlier than the edge after the output handshake.
- out_ready held low: DONE persists indefinitely with all outputs frozen.
- out_ready held high on arrival in DONE: result is consumed at the first DONE edge, so out_valid is high for exactly 1 cycle.
- Operand changes on a/b/bin after acceptance have no effect.

## Structure
- Package seq_sub_pkg:
  - state enum (IDLE, BUSY, DONE);
  - WIDTH = 64;
  - default CHUNK;
  - NCH derivation helper.
- Sub-module sub_chunk: combinational CHUNK-bit borrow subtractor (x, y, bi → d, bo), instantiated once and muxed by idx.
- Top module holds the FSM, operand/result registers and the handshake logic.

## Test plan
- Basic: a=5, b=3, bin=0 → diff=2, bout=0, ovf=0, zero=0. out_valid rises exactly 4 cycles after the accept edge (CHUNK=16).
- Borrow ripple across all chunks: a=0, b=1, bin=0 → diff=0xFFFF_FFFF_FFFF_FFFF, bout=1, ovf=0. Then a=0x0000_0001_0000_0000, b=1 → diff=0x0000_0000_FFFF_FFFF, bout=0.
- Signed overflow and zero:
  - a=0x8000_0000_0000_0000, b=1 → diff=0x7FFF_FFFF_FFFF_FFFF, ovf=1, bout=0;
  - a=b=0x3EBF_3EBF_3EBF_3EBF, bin=0 → zero=1;
  - same operands with bin=1 → diff=all ones, bout=1.
- Backpressure: hold out_ready=0 for 10 cycles while in_valid=1 with new operands → in_ready=0, the second operation is not accepted, and outputs stay frozen. Raising out_ready → handshake, IDLE, then the new operation is accepted.
- Reset mid-operation: drop rst_n for 1 cycle during BUSY (idx=2) → next cycle out_valid=0, diff=0, in_ready=1. The following operation completes with correct results.
- Parameter sweep: rerun the first three scenarios with CHUNK=8 and CHUNK=64 → identical results, with latency 8 and 1 respectively.
